imem_fetch_ctrl: RTL

Fetch controller and port arbiter for the single-port instruction memory. It owns the memory port and shares it between the core fetch path (reads) and the boot/program loader (writes), with the loader taking priority. It runs the fetch PC, keeps a 2-entry prefetch buffer, and delivers instructions to the decode stage over a valid/ready handshake. It handles redirects (branch/jump) by flushing stale fetches. The memory is the synchronous-read variant of the instruction memory: one access per cycle, with read data valid the cycle after the request.

---
 rtl/imem_fetch_ctrl_pkg.sv | 14 +
 rtl/imem_fetch_ctrl_if.sv | 16 +
 rtl/imem_prefetch_fifo.sv | 78 +++++++
 rtl/imem_fetch_ctrl.sv | 120 ++++++++++++
 4 files changed

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-memory fetch controller.
package imem_pkg;

    localparam int unsigned PC_W          = 32;
    localparam int unsigned INST_W        = 32;
    localparam int unsigned MEM_DEPTH_BIT = 18;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Single-port instruction memory bus: controller is master, memory is slave.
interface imem_fetch_ctrl_if
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_DEPTH_BIT,
    parameter int unsigned DATA_W = INST_W
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
    modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/imem_prefetch_fifo.sv
// Two-entry {pc, inst} prefetch buffer; flush overrides push and pop.
module imem_prefetch_fifo #(
    parameter int unsigned PC_W   = 32,
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [INST_W-1:0] push_inst,
    input  logic              pop,
    output logic [PC_W-1:0]   head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic [1:0]        count,
    output logic              full,
    output logic              empty
);
    logic [PC_W-1:0]   pc_q   [2];
    logic [PC_W-1:0]   pc_d   [2];
    logic [INST_W-1:0] inst_q [2];
    logic [INST_W-1:0] inst_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              push_ok, pop_ok;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;

    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign head_pc   = empty ? '0 : pc_q[rd_ptr_q];
    assign head_inst = empty ? '0 : inst_q[rd_ptr_q];

    always_comb begin
        pc_d     = pc_q;
        inst_d   = inst_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_ok) begin
                pc_d[wr_ptr_q]   = push_pc;
                inst_d[wr_ptr_q] = push_inst;
                wr_ptr_d         = ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + 2'(push_ok) - 2'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller and loader arbiter for the synchronous-read instruction memory.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned               PC_WIDTH_LENGTH   = PC_W,
    parameter int unsigned               INST_WIDTH_LENGTH = INST_W,
    parameter int unsigned               MAX_MEM_DEPTH_BIT = MEM_DEPTH_BIT,
    parameter logic [PC_WIDTH_LENGTH-1:0] RESET_PC         = PC_WIDTH_LENGTH'(RESET_PC_DEF)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH_LENGTH-1:0]   redirect_pc,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [INST_WIDTH_LENGTH-1:0] inst_data,
    output logic [PC_WIDTH_LENGTH-1:0]   inst_pc,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [MAX_MEM_DEPTH_BIT-1:0] ld_addr,
    input  logic [INST_WIDTH_LENGTH-1:0] ld_data,
    imem_fetch_ctrl_if.master            mem
);
    fetch_state_e               state_q, state_d;
    logic [PC_WIDTH_LENGTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH_LENGTH-1:0] rd_pc_q, rd_pc_d;
    logic                       epoch_q, epoch_d;
    logic                       rd_pend_q, rd_pend_d;
    logic                       rd_epoch_q, rd_epoch_d;

    logic       flush, issue, pop, push, room;
    logic [1:0] fifo_count;
    logic       fifo_full, fifo_empty;

    assign inst_valid = !fifo_empty;
    assign pop        = inst_valid && inst_ready;
    // credit = 2 - count - inflight + pop, expressed as a compare to stay unsigned
    assign room = ({1'b0, fifo_count} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, pop});
    assign push = rd_pend_q && (rd_epoch_q == epoch_q) && (!fifo_full || pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        epoch_d    = epoch_q;
        rd_pend_d  = 1'b0;
        rd_epoch_d = rd_epoch_q;
        rd_pc_d    = rd_pc_q;
        flush      = 1'b0;
        issue      = 1'b0;
        if (ld_valid) begin
            state_d = LOAD;
            flush   = 1'b1;
        end else if (state_q == LOAD) begin
            state_d    = RUN;
            fetch_pc_d = RESET_PC;
        end else if (redirect_valid) begin
            epoch_d    = ~epoch_q;
            flush      = 1'b1;
            fetch_pc_d = redirect_pc & ~PC_WIDTH_LENGTH'(3);
        end else if (room) begin
            issue      = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_WIDTH_LENGTH'(4);
            rd_pend_d  = 1'b1;
            rd_epoch_d = epoch_q;
            rd_pc_d    = fetch_pc_q;
        end
    end

    // Memory port is combinational so the memory samples the request at the
    // same edge the controller commits it; rst_n gates it to keep reset values.
    always_comb begin
        ld_ready      = rst_n && ld_valid;
        mem.mem_en    = rst_n && (ld_valid || issue);
        mem.mem_we    = rst_n && ld_valid;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (rst_n && ld_valid) begin
            mem.mem_addr  = ld_addr;
            mem.mem_wdata = ld_data;
        end else if (rst_n && issue) begin
            mem.mem_addr = fetch_pc_q[MAX_MEM_DEPTH_BIT+1:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            epoch_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_epoch_q <= 1'b0;
            rd_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            epoch_q    <= epoch_d;
            rd_pend_q  <= rd_pend_d;
            rd_epoch_q <= rd_epoch_d;
            rd_pc_q    <= rd_pc_d;
        end
    end

    imem_prefetch_fifo #(
        .PC_W   (PC_WIDTH_LENGTH),
        .INST_W (INST_WIDTH_LENGTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (push),
        .push_pc   (rd_pc_q),
        .push_inst (mem.mem_rdata),
        .pop       (pop),
        .head_pc   (inst_pc),
        .head_inst (inst_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
endmodule
